rti_core: RTL and testbench

- Real-time input (RTI) capture core; the receive-direction counterpart of the per-channel RTO cores.
- Tags each incoming event word with the free-running 64-bit timeline counter and buffers the 128-bit {timestamp, data} entry in an internal FIFO.
- The controller side drains the FIFO with a first-word-fall-through read port.
- Reports overflow (event dropped on full) and underflow (read when empty) with captured error data.

---
 rtl/rti_core.sv | 144 ++++++++++++++
 tb/tb_rti_core.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rti_core.sv
// Real-time input capture core.
// Each accepted event word is tagged with the 64-bit timeline counter and
// stored as a {timestamp, data} entry in an internal FIFO. The controller
// drains the FIFO through a first-word-fall-through port. The read path is a
// two-stage pipeline: a registered memory read stage and a presentation
// register. This gives a write-to-visible latency of two edges and still
// sustains one pop per cycle.
//
// Handshake: an entry is presented while empty=0. A pop happens on any edge
// where rd_en=1 and empty=0. rd_en with empty=1 changes nothing and raises
// underflow_error for one cycle. Events have no back-pressure. When full=1 a
// captured event is dropped, and overflow_error is raised for one cycle.
module rti_core #(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 13,
  parameter int PROG_FULL_THRESH = 8100,
  parameter int CHANGE_ONLY      = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         auto_start,
  input  logic [63:0]                  counter,
  input  logic                         event_valid,
  input  logic [DATA_WIDTH-1:0]        event_data,
  input  logic                         rd_en,
  output logic [64+DATA_WIDTH-1:0]     rti_out,
  output logic                         empty,
  output logic                         full,
  output logic [ADDR_WIDTH:0]          count,
  output logic                         overflow_error,
  output logic [64+DATA_WIDTH-1:0]     overflow_error_data,
  output logic                         underflow_error
);

  localparam int EW    = 64 + DATA_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] THRESH = (ADDR_WIDTH + 1)'(PROG_FULL_THRESH);

  logic [EW-1:0]         mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] last_data;
  logic [EW-1:0]         s1_data;
  logic                  s1_valid;
  logic [EW-1:0]         out_data;
  logic                  out_valid;
  logic                  full_q;
  logic                  ovf_q;
  logic [EW-1:0]         ovf_data_q;
  logic                  unf_q;

  logic capture;
  logic accept;
  logic drop;
  logic pop;
  logic under;
  logic mem_avail;
  logic s1_load;
  logic s2_load;

  // Capture, accept and drop decisions, plus the read pipeline advance terms.
  // Flush overrides every state-changing action on its edge.
  always_comb begin
    capture   = event_valid && auto_start &&
                ((CHANGE_ONLY == 0) || (event_data != last_data));
    accept    = capture && !full_q && !flush;
    drop      = capture && full_q && !flush;
    pop       = rd_en && out_valid && !flush;
    under     = rd_en && !out_valid && !flush;
    mem_avail = (wr_ptr != rd_ptr);
    s2_load   = s1_valid && (!out_valid || pop) && !flush;
    s1_load   = mem_avail && (!s1_valid || s2_load) && !flush;
  end

  // Entry storage. It has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {counter, event_data};
  end

  // Registered memory read stage.
  always_ff @(posedge clk) begin
    if (s1_load) s1_data <= mem[rd_ptr];
  end

  // Pointers, occupancy, presentation register and error reporting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      last_data  <= '0;
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_data_q <= '0;
      unf_q      <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      last_data  <= '0;
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_data_q <= '0;
      unf_q      <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        last_data <= event_data;
      end
      if (s1_load) rd_ptr <= rd_ptr + 1'b1;
      s1_valid <= s1_load || (s1_valid && !s2_load);
      if (s2_load) out_data <= s1_data;
      out_valid <= s2_load || (out_valid && !pop);
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Full lags count by one edge. The headroom above the threshold
      // absorbs the extra accept that this lag allows.
      full_q <= (count_q >= THRESH);
      ovf_q  <= drop;
      if (drop) ovf_data_q <= {counter, event_data};
      unf_q  <= under;
    end
  end

  assign rti_out             = out_data;
  assign empty               = !out_valid;
  assign full                = full_q;
  assign count               = count_q;
  assign overflow_error      = ovf_q;
  assign overflow_error_data = ovf_data_q;
  assign underflow_error     = unf_q;

endmodule

// File: tb/tb_rti_core.sv
// Bench for rti_core. Two instances share the stimulus: one instance
// captures every event, and the other captures only when the data changes.
// A reference model keeps an expected-entry queue per instance. A negedge
// monitor compares all outputs of both instances against that model.
module tb_rti_core;

  localparam int THRESH = 8100;

  logic         clk;
  logic         reset_n;
  logic         flush;
  logic         auto_start;
  logic [63:0]  counter;
  logic         event_valid;
  logic [63:0]  event_data;
  logic         rd_en;

  logic [127:0] rti0, rti1, oed0, oed1;
  logic         empty0, empty1, full0, full1, oe0, oe1, ue0, ue1;
  logic [13:0]  count0, count1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [127:0] d;
    logic [31:0]  acc;
  } ent_t;

  ent_t         exp_q [2][$];
  logic         m_full [2] = '{1'b0, 1'b0};
  logic         m_oe   [2] = '{1'b0, 1'b0};
  logic         m_ue   [2] = '{1'b0, 1'b0};
  logic [127:0] m_oed  [2] = '{128'd0, 128'd0};
  logic [63:0]  m_last [2] = '{64'd0, 64'd0};

  rti_core #(.CHANGE_ONLY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .auto_start(auto_start),
    .counter(counter), .event_valid(event_valid), .event_data(event_data),
    .rd_en(rd_en), .rti_out(rti0), .empty(empty0), .full(full0),
    .count(count0), .overflow_error(oe0), .overflow_error_data(oed0),
    .underflow_error(ue0)
  );

  rti_core #(.CHANGE_ONLY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .auto_start(auto_start),
    .counter(counter), .event_valid(event_valid), .event_data(event_data),
    .rd_en(rd_en), .rti_out(rti1), .empty(empty1), .full(full1),
    .count(count1), .overflow_error(oe1), .overflow_error_data(oed1),
    .underflow_error(ue1)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model of one edge. Entries are visible two edges after they
  // are accepted, and occupancy is simply the length of the queue.
  function automatic logic visible(input int k);
    return (exp_q[k].size() > 0) && (cyc >= int'(exp_q[k][0].acc) + 3);
  endfunction

  task automatic model_step(input int k);
    logic vis, capture, pop, accept, drop, new_full;
    vis = visible(k);
    if (flush) begin
      exp_q[k].delete();
      m_full[k] = 1'b0; m_oe[k] = 1'b0; m_ue[k] = 1'b0;
      m_oed[k]  = '0;   m_last[k] = '0;
      return;
    end
    capture  = event_valid && auto_start && (k == 0 || event_data != m_last[k]);
    pop      = rd_en && vis;
    accept   = capture && !m_full[k];
    drop     = capture && m_full[k];
    new_full = (exp_q[k].size() >= THRESH);
    m_ue[k]  = rd_en && !vis;
    m_oe[k]  = drop;
    if (drop) m_oed[k] = {counter, event_data};
    if (pop) void'(exp_q[k].pop_front());
    if (accept) begin
      exp_q[k].push_back('{d: {counter, event_data}, acc: 32'(cyc)});
      m_last[k] = event_data;
    end
    m_full[k] = new_full;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        for (int k = 0; k < 2; k++) begin
          exp_q[k].delete();
          m_full[k] = 1'b0; m_oe[k] = 1'b0; m_ue[k] = 1'b0;
          m_oed[k]  = '0;   m_last[k] = '0;
        end
        cyc++;
      end else begin
        model_step(0);
        model_step(1);
        cyc++;
      end
    end
  end

  // Monitor: compare every output of one instance against the model.
  task automatic mon(input int k, input logic e, input logic f, input logic [13:0] c,
                     input logic [127:0] o, input logic oe, input logic [127:0] oed,
                     input logic ue);
    logic vis;
    vis = visible(k);
    check($sformatf("dut%0d empty", k), {127'd0, e}, {127'd0, !vis});
    if (vis && !e) check($sformatf("dut%0d rti_out", k), o, exp_q[k][0].d);
    check($sformatf("dut%0d count", k), {114'd0, c}, 128'(exp_q[k].size()));
    check($sformatf("dut%0d full", k), {127'd0, f}, {127'd0, m_full[k]});
    check($sformatf("dut%0d overflow_error", k), {127'd0, oe}, {127'd0, m_oe[k]});
    check($sformatf("dut%0d overflow_error_data", k), oed, m_oed[k]);
    check($sformatf("dut%0d underflow_error", k), {127'd0, ue}, {127'd0, m_ue[k]});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0, empty0, full0, count0, rti0, oe0, oed0, ue0);
      mon(1, empty1, full1, count1, rti1, oe1, oed1, ue1);
    end
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [63:0] c, input logic [63:0] d);
    counter     = c;
    event_data  = d;
    event_valid = 1'b1;
    tick();
    event_valid = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain();
    rd_en = 1'b1;
    for (int i = 0; i < 9000 && !(empty0 && empty1); i++) tick();
    rd_en = 1'b0;
    check("drain completes", {126'd0, empty0, empty1}, 128'd3);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " empty"}, {127'd0, empty0}, 128'd1);
    check({tag, " full"}, {127'd0, full0}, 128'd0);
    check({tag, " count"}, {114'd0, count0}, 128'd0);
    check({tag, " rti_out"}, rti0, 128'd0);
    check({tag, " overflow_error"}, {127'd0, oe0}, 128'd0);
    check({tag, " overflow_error_data"}, oed0, 128'd0);
    check({tag, " underflow_error"}, {127'd0, ue0}, 128'd0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; auto_start = 1'b0; counter = '0;
    event_valid = 1'b0; event_data = '0; rd_en = 1'b0;
    tick(); tick();
    check_reset_values("reset");
    reset_n = 1'b1;
    auto_start = 1'b1;
    tick();

    // Basic capture and in-order readout.
    send(64'd100, 64'hA);
    send(64'd101, 64'hB);
    tick(); tick();
    check("basic head", rti0, {64'd100, 64'hA});
    check("basic count 2", {114'd0, count0}, 128'd2);
    pop_one();
    check("basic second", rti0, {64'd101, 64'hB});
    check("basic count 1", {114'd0, count0}, 128'd1);
    pop_one();
    check("basic empty", {127'd0, empty0}, 128'd1);
    check("basic count 0", {114'd0, count0}, 128'd0);

    // Latency and back-to-back pops.
    send(64'd10, 64'h100);
    check("latency +1", {127'd0, empty0}, 128'd1);
    send(64'd11, 64'h101);
    check("latency +2 before", {127'd0, empty0}, 128'd1);
    send(64'd12, 64'h102);
    check("latency +2", {127'd0, empty0}, 128'd0);
    send(64'd13, 64'h103);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("burst not empty", {127'd0, empty0}, 128'd0);
      check("burst entry", rti0, {64'(10 + i), 64'(256 + i)});
      tick();
    end
    rd_en = 1'b0;
    check("burst drained", {127'd0, empty0}, 128'd1);
    check("burst no underflow", {127'd0, ue0}, 128'd0);

    // Overflow: fill to the threshold, then drop one event.
    for (int i = 0; i < THRESH; i++) send(64'(i), 64'(i + 1));
    tick();
    check("ovf full", {127'd0, full0}, 128'd1);
    check("ovf count", {114'd0, count0}, 128'd8100);
    send(64'd9000, 64'h55);
    check("ovf pulse", {127'd0, oe0}, 128'd1);
    check("ovf data", oed0, {64'd9000, 64'h55});
    check("ovf count held", {114'd0, count0}, 128'd8100);
    tick();
    check("ovf pulse single", {127'd0, oe0}, 128'd0);
    check("ovf data held", oed0, {64'd9000, 64'h55});
    pop_one();
    check("ovf pop count", {114'd0, count0}, 128'd8099);
    check("ovf full lag", {127'd0, full0}, 128'd1);
    tick();
    check("ovf full clear", {127'd0, full0}, 128'd0);
    drain();

    // Change-only capture on the second instance.
    do_flush();
    send(64'd200, 64'd5);
    send(64'd201, 64'd5);
    send(64'd202, 64'd7);
    send(64'd203, 64'd7);
    send(64'd204, 64'd5);
    tick(); tick();
    check("change_only count", {114'd0, count1}, 128'd3);
    check("all count", {114'd0, count0}, 128'd5);
    check("change_only e0", rti1, {64'd200, 64'd5});
    pop_one();
    check("change_only e1", rti1, {64'd202, 64'd7});
    pop_one();
    check("change_only e2", rti1, {64'd204, 64'd5});
    drain();

    // Underflow and gating.
    pop_one();
    check("underflow pulse", {127'd0, ue0}, 128'd1);
    tick();
    check("underflow single", {127'd0, ue0}, 128'd0);
    auto_start = 1'b0;
    send(64'd300, 64'h1);
    send(64'd301, 64'h2);
    tick(); tick();
    check("gated count", {114'd0, count0}, 128'd0);
    check("gated empty", {127'd0, empty0}, 128'd1);
    auto_start = 1'b1;

    // Flush coincident with an event.
    send(64'd400, 64'h11);
    send(64'd401, 64'h12);
    send(64'd402, 64'h13);
    counter = 64'd403; event_data = 64'h14; event_valid = 1'b1; flush = 1'b1;
    tick();
    event_valid = 1'b0; flush = 1'b0;
    check("flush count", {114'd0, count0}, 128'd0);
    check("flush empty", {127'd0, empty0}, 128'd1);
    tick(); tick();
    check("flush event dropped", {127'd0, empty0}, 128'd1);

    // Asynchronous reset during a burst.
    send(64'd500, 64'h21);
    send(64'd501, 64'h22);
    counter = 64'd502; event_data = 64'h23; event_valid = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    check_reset_values("async reset");
    event_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("release no ovf", {127'd0, oe0}, 128'd0);
    check("release no unf", {127'd0, ue0}, 128'd0);
    send(64'd55, 64'h99);
    tick(); tick();
    check("after reset entry", rti0, {64'd55, 64'h99});
    drain();

    // Counter wrap.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    send(64'h0, 64'h2);
    tick(); tick();
    check("wrap entry", rti0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h1});
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      event_valid = 1'($urandom_range(0, 1));
      auto_start  = ($urandom_range(0, 7) != 0);
      event_data  = 64'($urandom_range(0, 3));
      counter     = {$urandom, $urandom};
      rd_en       = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 39) == 0);
      tick();
    end
    event_valid = 1'b0; flush = 1'b0; rd_en = 1'b0; auto_start = 1'b1;
    tick(); tick();
    drain();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
